// File: rtl/div_pkg.sv
// Shared types and constants for the RV32M divide/remainder sequencer.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    localparam logic [6:0] M_FUNCT7 = 7'b0000001;

endpackage

// File: rtl/div_sequencer_if.sv
// EX-stage handshake between the pipeline and the divide sequencer.
interface div_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, dividend, divisor, flush,
        input  stall, busy, done, result
    );

    modport slave (
        input  start, funct3, dividend, divisor, flush,
        output stall, busy, done, result
    );
endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division iteration on unsigned magnitudes.
module div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);
    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    // rem < divisor always holds, so the shifted partial remainder fits XLEN+1 bits
    // and bit XLEN of the trial is a clean borrow flag.
    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        trial   = shifted - {1'b0, dvs_i};
        rem_o   = shifted[XLEN-1:0];
        quo_o   = {quo_i[XLEN-2:0], 1'b0};
        if (!trial[XLEN]) begin
            rem_o    = trial[XLEN-1:0];
            quo_o[0] = 1'b1;
        end
    end
endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer: IDLE -> CALC (XLEN cycles) -> FIX -> DONE,
// with a one-cycle shortcut to DONE for divide-by-zero and signed overflow.
module div_sequencer
    import div_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    div_sequencer_if.slave bus
);
    localparam int unsigned CW = $clog2(XLEN);

    div_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            is_rem_q, is_rem_d;
    logic            dvd_neg_q, dvd_neg_d;
    logic            quo_neg_q, quo_neg_d;
    logic            busy_q;

    logic [XLEN-1:0] step_rem, step_quo;
    logic            is_signed, is_rem, a_neg, b_neg, div_zero, ovf, accept;

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // Unlisted funct3 encodings fall through to unsigned quotient.
    always_comb begin
        is_signed = (bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM);
        is_rem    = (bus.funct3 == F3_REM) || (bus.funct3 == F3_REMU);
        a_neg     = is_signed && bus.dividend[XLEN-1];
        b_neg     = is_signed && bus.divisor[XLEN-1];
        div_zero  = (bus.divisor == '0);
        ovf       = is_signed && (bus.dividend == {1'b1, {(XLEN-1){1'b0}}})
                    && (bus.divisor == '1);
        accept    = (state_q == IDLE) && bus.start && !bus.flush;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        res_d     = res_q;
        is_rem_d  = is_rem_q;
        dvd_neg_d = dvd_neg_q;
        quo_neg_d = quo_neg_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    is_rem_d  = is_rem;
                    dvd_neg_d = a_neg;
                    quo_neg_d = a_neg ^ b_neg;
                    if (div_zero) begin
                        res_d   = is_rem ? bus.dividend : '1;
                        state_d = DONE;
                    end else if (ovf) begin
                        res_d   = is_rem ? '0 : bus.dividend;
                        state_d = DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = a_neg ? -bus.dividend : bus.dividend;
                        dvs_d   = b_neg ? -bus.divisor : bus.divisor;
                        cnt_d   = CW'(XLEN - 1);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                if (is_rem_q) begin
                    res_d = dvd_neg_q ? -rem_q : rem_q;
                end else begin
                    res_d = quo_neg_q ? -quo_q : quo_q;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (bus.flush) begin
            state_d = IDLE;
            res_d   = res_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            res_q     <= '0;
            is_rem_q  <= 1'b0;
            dvd_neg_q <= 1'b0;
            quo_neg_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            res_q     <= res_d;
            is_rem_q  <= is_rem_d;
            dvd_neg_q <= dvd_neg_d;
            quo_neg_q <= quo_neg_d;
            busy_q    <= (state_d != IDLE);
        end
    end

    always_comb begin
        bus.stall  = accept || (state_q == CALC) || (state_q == FIX);
        bus.busy   = busy_q;
        bus.done   = (state_q == DONE);
        bus.result = res_q;
    end
endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: directed vector table, flush/reset sequences and random ops vs. an arithmetic model.
module tb_div_sequencer;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    div_sequencer_if #(.XLEN(32)) bus ();

    div_sequencer #(.XLEN(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic is_sgn(input logic [2:0] f3);
        return (f3 == 3'b100) || (f3 == 3'b110);
    endfunction

    function automatic logic is_rmd(input logic [2:0] f3);
        return (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    function automatic logic special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (is_sgn(f3) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // RISC-V M-extension semantics using the simulator's own division.
    function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        if (b == 32'd0) begin
            r = is_rmd(f3) ? a : 32'hFFFF_FFFF;
        end else if (is_sgn(f3)) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = is_rmd(f3) ? 32'd0 : a;
            else if (is_rmd(f3)) r = $signed(a) % $signed(b);
            else r = $signed(a) / $signed(b);
        end else begin
            r = is_rmd(f3) ? (a % b) : (a / b);
        end
        return r;
    endfunction

    // Entered and left at posedge+1; cycle 0 is the start cycle.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input int flush_at, input logic [31:0] exp_res, input string tag);
        int lat, ncyc, done_cnt, done_at, stall_cnt, stall_last, busy_cnt, busy_first;
        logic [31:0] res;
        lat = special(f3, a, b) ? 1 : 34;
        ncyc = (flush_at >= 0) ? flush_at + 4 : lat + 1;
        done_cnt = 0; done_at = -1; stall_cnt = 0; stall_last = -1;
        busy_cnt = 0; busy_first = -1; res = '0;
        for (int c = 0; c < ncyc; c++) begin
            bus.start    = (c == 0);
            bus.funct3   = f3;
            bus.dividend = a;
            bus.divisor  = b;
            bus.flush    = (c == flush_at);
            @(negedge clk);
            if (bus.done) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (bus.stall) begin
                stall_cnt++;
                stall_last = c;
            end
            if (bus.busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = c;
            end
            res = bus.result;
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk({tag, " result"}, res, exp_res);
        if (flush_at >= 0) begin
            chk({tag, " done count"}, done_cnt, 0);
            chk({tag, " stall count"}, stall_cnt, flush_at + 1);
            chk({tag, " stall last"}, stall_last, flush_at);
            chk({tag, " busy count"}, busy_cnt, flush_at);
        end else begin
            chk({tag, " done count"}, done_cnt, 1);
            chk({tag, " done cycle"}, done_at, lat);
            chk({tag, " stall count"}, stall_cnt, lat);
            chk({tag, " stall last"}, stall_last, lat - 1);
            chk({tag, " busy count"}, busy_cnt, lat);
            chk({tag, " busy first"}, busy_first, 1);
        end
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] a, b;
        logic [2:0]  f3;
        int          mode;
        logic        pre_busy;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = 3'b101;
        bus.dividend = '0; bus.divisor = '0;

        vecs.push_back('{3'b101, 32'd100, 32'd7, 32'd14, "DIVU 100/7"});
        vecs.push_back('{3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "DIV -7/2"});
        vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "REM -7/2"});
        vecs.push_back('{3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, "REM 7/-2"});
        vecs.push_back('{3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, "DIV 7/-2"});
        vecs.push_back('{3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, "DIVU 5/0"});
        vecs.push_back('{3'b111, 32'd5, 32'd0, 32'd5, "REMU 5/0"});
        vecs.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "DIV ovf"});
        vecs.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "REM ovf"});
        vecs.push_back('{3'b000, 32'd100, 32'd7, 32'd14, "f3=000 as DIVU"});
        vecs.push_back('{3'b111, 32'hFFFF_FFFF, 32'd10, 32'd5, "REMU max/10"});

        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", {31'd0, bus.busy}, 32'd0);
        chk("reset done", {31'd0, bus.done}, 32'd0);
        chk("reset result", bus.result, 32'd0);
        chk("reset stall idle", {31'd0, bus.stall}, 32'd0);
        bus.start = 1'b1;
        #1;
        chk("reset stall follows start", {31'd0, bus.stall}, 32'd1);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) run_op(vecs[i].f3, vecs[i].a, vecs[i].b, -1, vecs[i].exp, vecs[i].name);

        // Flush mid-CALC must leave the previous result intact.
        run_op(3'b101, 32'd100, 32'd7, -1, 32'd14, "pre-flush");
        run_op(3'b101, 32'd1000, 32'd10, 10, 32'd14, "flush@10");
        run_op(3'b101, 32'd9, 32'd3, -1, 32'd3, "DIVU 9/3 after flush");

        // Asynchronous reset in cycle 15 of a DIVU.
        bus.start = 1'b1; bus.funct3 = 3'b101; bus.dividend = 32'd1000; bus.divisor = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        pre_busy = bus.busy;
        chk("busy before reset", {31'd0, pre_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async rst busy", {31'd0, bus.busy}, 32'd0);
        chk("async rst done", {31'd0, bus.done}, 32'd0);
        chk("async rst result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(3'b101, 32'd1, 32'd1, -1, 32'd1, "DIVU 1/1 after reset");

        for (int n = 0; n < 40; n++) begin
            f3   = 3'($urandom_range(0, 7));
            mode = $urandom_range(0, 9);
            a    = $urandom;
            b    = $urandom;
            if (mode == 0) b = 32'd0;
            else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; f3 = {2'b1_0, f3[0]} ^ 3'b000; end
            else if (mode == 2) begin
                a = 32'($urandom_range(0, 50));
                b = 32'($urandom_range(1, 9));
                if ($urandom_range(0, 1) == 1) a = -a;
                if ($urandom_range(0, 1) == 1) b = -b;
            end else if (mode < 6) b = b >> $urandom_range(0, 31);
            if (b == 32'd0 && mode != 0) b = 32'd3;
            run_op(f3, a, b, -1, ref_div(f3, a, b), $sformatf("rand%0d f3=%0d", n, f3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
